// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch sequencer: FSM states, FIFO entry layout, defaults.
package fetch_pkg;

    typedef enum logic [1:0] {
        StBoot,
        StReq,
        StWait,
        StDiscard
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One buffered fetch: the instruction address, its successor and the word itself.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-side bus bundle: redirect input, instruction memory port and decode handshake.
interface fetch_if;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;
    logic        fetch_err;

    // Sequencer side.
    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_pc, out_pc_plus4, out_instr, fetch_err
    );

    // Memory / decode / EX side.
    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_pc, out_pc_plus4, out_instr, fetch_err
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is read combinationally, no write-to-read bypass.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign valid   = (count_q != '0);
    assign do_pop  = pop && valid;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointer and occupancy tracking; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage array, written on accepted pushes.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer with redirect flush.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

    fetch_state_t   state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    pc_issued_q, pc_issued_d;
    logic           fetch_err_q;
    logic           req;
    logic           push;
    logic           pop;
    logic           head_valid;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t   push_entry;
    fetch_entry_t   head_entry;
    logic           slot_free;
    logic           granted;

    // A request is only raised when the response already has a FIFO slot reserved.
    assign slot_free = (fifo_count < DEPTH_CNT);
    assign granted   = req && bus.imem_gnt;

    // Next-state, PC update and memory request generation; redirect overrides everything.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_issued_d = pc_issued_q;
        req         = 1'b0;
        push        = 1'b0;

        unique case (state_q)
            StBoot: state_d = StReq;
            StReq: begin
                req = slot_free;
                if (req && bus.imem_gnt) begin
                    pc_d        = pc_q + 32'd4;
                    pc_issued_d = pc_q;
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (bus.imem_rvalid) begin
                    push    = 1'b1;
                    state_d = StReq;
                end
            end
            StDiscard: begin
                if (bus.imem_rvalid) state_d = StReq;
            end
            default: state_d = StBoot;
        endcase

        if (bus.redirect_valid) begin
            pc_d = align_word(bus.redirect_pc);
            push = 1'b0;
            unique case (state_q)
                StBoot:    state_d = StReq;
                StReq:     state_d = granted ? StDiscard : StReq;
                StWait:    state_d = bus.imem_rvalid ? StReq : StDiscard;
                // Response that arrives alongside the redirect is the stale one being awaited.
                StDiscard: state_d = bus.imem_rvalid ? StReq : StDiscard;
                default:   state_d = StBoot;
            endcase
        end
    end

    // State, PC and misaligned-redirect flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StBoot;
            pc_q        <= RESET_PC;
            pc_issued_q <= RESET_PC;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_issued_q <= pc_issued_d;
            fetch_err_q <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
        end
    end

    assign push_entry = '{pc: pc_issued_q, pc4: pc_issued_q + 32'd4, instr: bus.imem_rdata};

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect_valid),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .valid (head_valid),
        .rdata (head_entry),
        .count (fifo_count)
    );

    // Head is hidden from decode during a redirect so nothing stale is consumed.
    assign bus.out_valid    = head_valid && !bus.redirect_valid;
    assign pop              = bus.out_valid && bus.out_ready;
    assign bus.out_pc       = head_entry.pc;
    assign bus.out_pc_plus4 = head_entry.pc4;
    assign bus.out_instr    = head_entry.instr;
    assign bus.imem_req     = req;
    assign bus.imem_addr    = pc_q;
    assign bus.fetch_err    = fetch_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a small instruction memory model.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   mem_lat = 1;

    fetch_if bus ();

    fetch_sequencer #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {8'h13, a[23:0]} ^ 32'h0055_AA00;
    endfunction

    // Memory model: accepts on req&gnt (sampled mid-cycle), answers mem_lat cycles later.
    logic        new_req;
    logic [31:0] new_addr;
    logic        pend_valid = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt = 0;

    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            new_req  = (bus.imem_req === 1'b1) && (bus.imem_gnt === 1'b1);
            new_addr = bus.imem_addr;
            @(posedge clk);
            #1;
            bus.imem_rvalid = 1'b0;
            if (pend_valid) begin
                pend_cnt = pend_cnt - 1;
                if (pend_cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = instr_of(pend_addr);
                    pend_valid      = 1'b0;
                end
            end
            if (new_req) begin
                if (mem_lat == 1) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = instr_of(new_addr);
                end else begin
                    pend_valid = 1'b1;
                    pend_addr  = new_addr;
                    pend_cnt   = mem_lat - 1;
                end
            end
        end
    end

    // Holds reset for a few cycles; returns just after the release edge (cycle 0).
    task automatic do_reset();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_gnt       = 1'b1;
        bus.out_ready      = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Waits (bounded) for a handshake on the decode side and reports the popped head.
    task automatic wait_pop(input int limit, output bit ok, output logic [31:0] pc,
                            output logic [31:0] pc4, output logic [31:0] instr, output int waited);
        ok = 1'b0;
        waited = 0;
        pc = '0;
        pc4 = '0;
        instr = '0;
        for (int i = 1; i <= limit && !ok; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                ok     = 1'b1;
                pc     = bus.out_pc;
                pc4    = bus.out_pc_plus4;
                instr  = bus.out_instr;
                waited = i;
            end
        end
    endtask

    task automatic test_reset();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_gnt       = 1'b1;
        bus.out_ready      = 1'b1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total_cnt++;
        if ({bus.imem_req, bus.out_valid, bus.fetch_err} !== 3'b000)
            $display("FAIL reset_outputs: got req/valid/err=%b required 000",
                     {bus.imem_req, bus.out_valid, bus.fetch_err});
        else pass_cnt++;
        do_reset();
        @(negedge clk);
        total_cnt++;
        if (bus.imem_req !== 1'b0) $display("FAIL boot_no_req: got %b required 0", bus.imem_req);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        bit ok;
        logic [31:0] pc, pc4, instr;
        int waited;
        mem_lat = 1;
        do_reset();
        @(negedge clk); // cycle 0
        @(negedge clk); // cycle 1
        total_cnt++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0)
            $display("FAIL first_req: got req=%b addr=%h required req=1 addr=00000000",
                     bus.imem_req, bus.imem_addr);
        else pass_cnt++;
        @(negedge clk); // cycle 2
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL no_bypass: got out_valid=%b required 0", bus.out_valid);
        else pass_cnt++;
        @(negedge clk); // cycle 3
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_pc_plus4 !== 32'h4 ||
            bus.out_instr !== instr_of(32'h0))
            $display("FAIL first_out: got v=%b pc=%h pc4=%h instr=%h required v=1 pc=0 pc4=4 instr=%h",
                     bus.out_valid, bus.out_pc, bus.out_pc_plus4, bus.out_instr, instr_of(32'h0));
        else pass_cnt++;
        for (int k = 1; k <= 2; k++) begin
            wait_pop(10, ok, pc, pc4, instr, waited);
            total_cnt++;
            if (!ok || pc !== 32'(4 * k) || pc4 !== 32'(4 * k + 4) || instr !== instr_of(32'(4 * k))
                || waited != 2)
                $display("FAIL stream_pc%0d: got ok=%0d pc=%h pc4=%h instr=%h gap=%0d required pc=%h gap=2",
                         k, ok, pc, pc4, instr, waited, 32'(4 * k));
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] pc, pc4, instr;
        int waited;
        int reqs;
        mem_lat = 1;
        do_reset();
        bus.out_ready = 1'b0;
        reqs = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1) reqs++;
        end
        total_cnt++;
        if (reqs != 2) $display("FAIL bp_req_count: got %0d requests required 2", reqs);
        else pass_cnt++;
        total_cnt++;
        if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0)
            $display("FAIL bp_hold: got req=%b v=%b pc=%h required req=0 v=1 pc=0",
                     bus.imem_req, bus.out_valid, bus.out_pc);
        else pass_cnt++;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_pop(10, ok, pc, pc4, instr, waited);
            total_cnt++;
            if (!ok || pc !== 32'(4 * k) || instr !== instr_of(32'(4 * k)) || (k < 2 && waited != 1))
                $display("FAIL bp_release%0d: got ok=%0d pc=%h instr=%h wait=%0d required pc=%h",
                         k, ok, pc, instr, waited, 32'(4 * k));
            else pass_cnt++;
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        logic [31:0] pc, pc4, instr;
        int waited;
        mem_lat = 2;
        do_reset();
        @(negedge clk); // cycle 0
        @(negedge clk); // cycle 1: request 0x0
        @(negedge clk); // cycle 2: WAIT, response still pending
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        @(posedge clk);
        #1 bus.redirect_valid = 1'b0;
        @(negedge clk); // cycle 3: stale response arrives
        total_cnt++;
        if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL rw_discard: got req=%b v=%b required 0 0", bus.imem_req, bus.out_valid);
        else pass_cnt++;
        @(negedge clk); // cycle 4
        total_cnt++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.out_valid !== 1'b0)
            $display("FAIL rw_refetch: got req=%b addr=%h v=%b required 1 00000100 0",
                     bus.imem_req, bus.imem_addr, bus.out_valid);
        else pass_cnt++;
        wait_pop(12, ok, pc, pc4, instr, waited);
        total_cnt++;
        if (!ok || pc !== 32'h100 || instr !== instr_of(32'h100))
            $display("FAIL rw_first_pop: got ok=%0d pc=%h instr=%h required pc=00000100 instr=%h",
                     ok, pc, instr, instr_of(32'h100));
        else pass_cnt++;
        mem_lat = 1;
    endtask

    task automatic test_redirect_gnt();
        bit ok;
        bit found;
        logic [31:0] pc, pc4, instr;
        int waited;
        mem_lat = 1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1 && bus.imem_addr === 32'h8) found = 1'b1;
        end
        total_cnt++;
        if (!found) $display("FAIL rg_find_req8: got no request for 00000008 required one");
        else pass_cnt++;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL rg_valid_masked: got %b required 0", bus.out_valid);
        else pass_cnt++;
        @(posedge clk);
        #1 bus.redirect_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL rg_discard: got req=%b v=%b required 0 0", bus.imem_req, bus.out_valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200)
            $display("FAIL rg_new_addr: got req=%b addr=%h required 1 00000200",
                     bus.imem_req, bus.imem_addr);
        else pass_cnt++;
        wait_pop(10, ok, pc, pc4, instr, waited);
        total_cnt++;
        if (!ok || pc !== 32'h200 || instr !== instr_of(32'h200))
            $display("FAIL rg_first_pop: got ok=%0d pc=%h instr=%h required pc=00000200", ok, pc, instr);
        else pass_cnt++;
    endtask

    task automatic test_fetch_err();
        bit ok;
        bit found;
        logic [31:0] pc, pc4, instr;
        int waited;
        mem_lat = 1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) found = 1'b1;
        end
        total_cnt++;
        if (!found || bus.fetch_err !== 1'b0)
            $display("FAIL fe_pre: got found=%0d err=%b required 1 0", found, bus.fetch_err);
        else pass_cnt++;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        @(posedge clk);
        #1 bus.redirect_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus.fetch_err !== 1'b1) $display("FAIL fe_pulse: got %b required 1", bus.fetch_err);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.fetch_err !== 1'b0) $display("FAIL fe_one_cycle: got %b required 0", bus.fetch_err);
        else pass_cnt++;
        wait_pop(10, ok, pc, pc4, instr, waited);
        total_cnt++;
        if (!ok || pc !== 32'h100 || pc4 !== 32'h104)
            $display("FAIL fe_aligned_pop: got ok=%0d pc=%h pc4=%h required 00000100 00000104",
                     ok, pc, pc4);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        bit ok;
        logic [31:0] pc, pc4, instr;
        int waited;
        mem_lat = 1;
        do_reset();
        @(negedge clk); // cycle 0
        @(negedge clk); // cycle 1: request granted alongside the redirect
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        @(posedge clk);
        #1 bus.redirect_valid = 1'b0;
        wait_pop(10, ok, pc, pc4, instr, waited);
        total_cnt++;
        if (!ok || pc !== 32'hFFFF_FFFC || pc4 !== 32'h0)
            $display("FAIL wrap_pc4: got ok=%0d pc=%h pc4=%h required FFFFFFFC 00000000", ok, pc, pc4);
        else pass_cnt++;
        wait_pop(10, ok, pc, pc4, instr, waited);
        total_cnt++;
        if (!ok || pc !== 32'h0 || instr !== instr_of(32'h0))
            $display("FAIL wrap_next: got ok=%0d pc=%h required 00000000", ok, pc);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        bit ok;
        bit found;
        logic [31:0] pc, pc4, instr;
        int waited;
        int early_valid;
        mem_lat = 2;
        do_reset();
        bus.out_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) found = 1'b1;
        end
        @(negedge clk); // WAIT with one entry buffered, response pending
        total_cnt++;
        if (!found || bus.imem_req !== 1'b0 || bus.out_valid !== 1'b1)
            $display("FAIL ar_setup: got found=%0d req=%b v=%b required 1 0 1",
                     found, bus.imem_req, bus.out_valid);
        else pass_cnt++;
        #1 rst = 1'b0;
        #1;
        total_cnt++;
        if ({bus.imem_req, bus.out_valid, bus.fetch_err} !== 3'b000)
            $display("FAIL ar_immediate: got req/valid/err=%b required 000",
                     {bus.imem_req, bus.out_valid, bus.fetch_err});
        else pass_cnt++;
        @(posedge clk);
        #1 rst = 1'b1;
        bus.out_ready = 1'b1;
        early_valid = 0;
        @(negedge clk); // cycle 0, late response arrives here
        if (bus.out_valid !== 1'b0) early_valid++;
        @(negedge clk); // cycle 1
        if (bus.out_valid !== 1'b0) early_valid++;
        total_cnt++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0)
            $display("FAIL ar_restart: got req=%b addr=%h required 1 00000000",
                     bus.imem_req, bus.imem_addr);
        else pass_cnt++;
        @(negedge clk); // cycle 2
        if (bus.out_valid !== 1'b0) early_valid++;
        total_cnt++;
        if (early_valid != 0)
            $display("FAIL ar_late_rvalid: got %0d early valid cycles required 0", early_valid);
        else pass_cnt++;
        wait_pop(10, ok, pc, pc4, instr, waited);
        total_cnt++;
        if (!ok || pc !== 32'h0 || instr !== instr_of(32'h0))
            $display("FAIL ar_first_pop: got ok=%0d pc=%h instr=%h required 00000000 %h",
                     ok, pc, instr, instr_of(32'h0));
        else pass_cnt++;
        mem_lat = 1;
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_gnt       = 1'b0;
        bus.out_ready      = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_gnt();
        test_fetch_err();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
